stream_ena_sched: RTL and testbench



---
 rtl/stream_ena_sched_pkg.sv | 26 ++
 rtl/stream_ena_sched_onehot_lowest.sv | 14 +
 rtl/stream_ena_sched.sv | 135 +++++++++++++
 tb/tb_stream_ena_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_ena_sched_pkg.sv
// Shared encodings and unit indices for the decoder enable scheduler.
package stream_ena_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_RUN    = 2'd0,
    SCHED_DRAIN  = 2'd1,
    SCHED_PAUSED = 2'd2
  } sched_state_e;

  localparam int SYN_SPS          = 0;
  localparam int SYN_PPS          = 1;
  localparam int SYN_SLICE_HEADER = 2;
  localparam int SYN_SLICE_DATA   = 3;

  localparam int BK_INTRA   = 0;
  localparam int BK_INTER   = 1;
  localparam int BK_SUM     = 2;
  localparam int BK_EXT_WR  = 3;
  localparam int BK_EXT_HUB = 4;

  // Drain counter must hold DRAIN_CYCLES; a zero-cycle drain still needs one bit.
  function automatic int drain_cnt_w(input int dc);
    return (dc > 0) ? $clog2(dc + 1) : 1;
  endfunction

endpackage

// File: rtl/stream_ena_sched_onehot_lowest.sv
// Reduces a select vector to its lowest set bit and flags multi-hot input.
module onehot_lowest #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_vec,
  output logic [W-1:0] o_lowest,
  output logic         o_multi
);

  // Two's-complement isolate: x & -x keeps only the lowest set bit.
  assign o_lowest = i_vec & (~i_vec + W'(1));
  assign o_multi  = |(i_vec ^ o_lowest);

endmodule

// File: rtl/stream_ena_sched.sv
// Per-unit enable scheduler with pause/drain FSM, starvation counter and select checking.
module stream_ena_sched
  import stream_ena_sched_pkg::*;
#(
  parameter int NUM_SYNTAX   = 4,
  parameter int NUM_BACK     = 5,
  parameter int DRAIN_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  stream_mem_valid,
  input  logic                  rbsp_buffer_valid,
  input  logic [NUM_SYNTAX-1:0] syntax_sel,
  input  logic                  pause_req,
  input  logic                  stall_clr,
  output logic                  read_nalu_ena,
  output logic                  rbsp_buffer_ena,
  output logic                  bc_ena,
  output logic [NUM_SYNTAX-1:0] syntax_ena,
  output logic                  residual_ena,
  output logic [NUM_BACK-1:0]   back_ena,
  output logic                  pause_ack,
  output logic [1:0]            sched_state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  sel_err
);

  localparam int             DCW        = drain_cnt_w(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  sched_state_e          r_state;
  logic                  r_pause_ack;
  logic [DCW-1:0]        r_drain_cnt;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic                  r_sel_err;

  logic [NUM_SYNTAX-1:0] w_sel_1h;
  logic                  w_sel_multi;
  logic                  w_run;
  logic                  w_drain;
  logic                  w_front;
  logic                  w_parse;
  logic                  w_back;

  onehot_lowest #(.W(NUM_SYNTAX)) u_sel (
    .i_vec    (syntax_sel),
    .o_lowest (w_sel_1h),
    .o_multi  (w_sel_multi)
  );

  // rst_n gates the state decode so every enable is low while reset is held.
  assign w_run   = rst_n & (r_state == SCHED_RUN);
  assign w_drain = rst_n & (r_state == SCHED_DRAIN);
  assign w_front = w_run & ena & stream_mem_valid;
  assign w_parse = w_run & ena & rbsp_buffer_valid;
  assign w_back  = (w_run | w_drain) & ena;

  assign read_nalu_ena   = w_front;
  assign rbsp_buffer_ena = w_front;
  assign bc_ena          = w_parse;
  assign residual_ena    = w_parse;
  assign syntax_ena      = {NUM_SYNTAX{w_parse}} & w_sel_1h;
  assign back_ena        = {NUM_BACK{w_back}};

  assign pause_ack   = r_pause_ack;
  assign sched_state = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign sel_err     = r_sel_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SCHED_RUN;
      r_pause_ack <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        SCHED_RUN: begin
          if (pause_req) begin
            if (DRAIN_CYCLES > 0) begin
              r_state     <= SCHED_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end else begin
              r_state     <= SCHED_PAUSED;
              r_pause_ack <= 1'b1;
            end
          end
        end
        SCHED_DRAIN: begin
          // Abort is checked first so a dropped request beats counter expiry.
          if (!pause_req) begin
            r_state     <= SCHED_RUN;
            r_drain_cnt <= '0;
          end else if (ena) begin
            if (r_drain_cnt == DCW'(1)) begin
              r_state     <= SCHED_PAUSED;
              r_pause_ack <= 1'b1;
              r_drain_cnt <= '0;
            end else begin
              r_drain_cnt <= r_drain_cnt - DCW'(1);
            end
          end
        end
        SCHED_PAUSED: begin
          if (!pause_req) begin
            r_state     <= SCHED_RUN;
            r_pause_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= SCHED_RUN;
          r_pause_ack <= 1'b0;
          r_drain_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_sel_err   <= 1'b0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      if (w_run & ena & ~rbsp_buffer_valid & ~&r_stall_cnt)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_parse & w_sel_multi)
        r_sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_ena_sched.sv
// Bench for stream_ena_sched: three parameterisations share one stimulus stream.
module tb_stream_ena_sched;
  logic clk, rst_n, ena, smv, rbv, pr, clr;
  logic [3:0] sel;
  logic [2:0] rn, rb, bc, re, pa, se;
  logic [2:0][3:0] sy;
  logic [2:0][4:0] bk;
  logic [2:0][1:0] ss;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int checks = 0, failures = 0;
  int m_st[3], m_rem[3], m_stall[3];
  bit m_err[3];
  int dcp[3] = '{16, 0, 3};
  int cwp[3] = '{16, 16, 4};

  stream_ena_sched #(.DRAIN_CYCLES(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .stream_mem_valid(smv), .rbsp_buffer_valid(rbv),
    .syntax_sel(sel), .pause_req(pr), .stall_clr(clr), .read_nalu_ena(rn[0]),
    .rbsp_buffer_ena(rb[0]), .bc_ena(bc[0]), .syntax_ena(sy[0]), .residual_ena(re[0]),
    .back_ena(bk[0]), .pause_ack(pa[0]), .sched_state(ss[0]), .stall_cnt(sc0), .sel_err(se[0]));
  stream_ena_sched #(.DRAIN_CYCLES(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .stream_mem_valid(smv), .rbsp_buffer_valid(rbv),
    .syntax_sel(sel), .pause_req(pr), .stall_clr(clr), .read_nalu_ena(rn[1]),
    .rbsp_buffer_ena(rb[1]), .bc_ena(bc[1]), .syntax_ena(sy[1]), .residual_ena(re[1]),
    .back_ena(bk[1]), .pause_ack(pa[1]), .sched_state(ss[1]), .stall_cnt(sc1), .sel_err(se[1]));
  stream_ena_sched #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .stream_mem_valid(smv), .rbsp_buffer_valid(rbv),
    .syntax_sel(sel), .pause_req(pr), .stall_clr(clr), .read_nalu_ena(rn[2]),
    .rbsp_buffer_ena(rb[2]), .bc_ena(bc[2]), .syntax_ena(sy[2]), .residual_ena(re[2]),
    .back_ena(bk[2]), .pause_ack(pa[2]), .sched_state(ss[2]), .stall_cnt(sc2), .sel_err(se[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  // Reference: state as plain ints (0 run, 1 drain, 2 paused) stepped by the rules.
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit run, drn, found;
      logic [3:0] esy;
      logic [15:0] gsc;
      run = rst_n && m_st[k] == 0;
      drn = rst_n && m_st[k] == 1;
      esy = 4'd0; found = 0;
      for (int i = 0; i < 4; i++)
        if (!found && sel[i]) begin found = 1; if (run && ena && rbv) esy[i] = 1'b1; end
      gsc = (k == 0) ? sc0 : (k == 1) ? sc1 : {12'd0, sc2};
      chk("read_nalu_ena", k, rn[k], run && ena && smv);
      chk("rbsp_buffer_ena", k, rb[k], run && ena && smv);
      chk("bc_ena", k, bc[k], run && ena && rbv);
      chk("residual_ena", k, re[k], run && ena && rbv);
      chk("syntax_ena", k, sy[k], esy);
      chk("back_ena", k, bk[k], ((run || drn) && ena) ? 5'h1f : 5'h00);
      chk("pause_ack", k, pa[k], m_st[k] == 2);
      chk("sched_state", k, ss[k], m_st[k]);
      chk("stall_cnt", k, gsc, m_stall[k]);
      chk("sel_err", k, se[k], m_err[k]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_st[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_err[k] = 0;
        continue;
      end
      if (clr) begin
        m_stall[k] = 0; m_err[k] = 0;
      end else if (m_st[k] == 0 && ena) begin
        if (!rbv && m_stall[k] < (1 << cwp[k]) - 1) m_stall[k]++;
        if (rbv && $countones(sel) > 1) m_err[k] = 1;
      end
      case (m_st[k])
        0: if (pr) begin
             if (dcp[k] > 0) begin m_st[k] = 1; m_rem[k] = dcp[k]; end
             else m_st[k] = 2;
           end
        1: if (!pr) m_st[k] = 0;
           else if (ena) begin
             m_rem[k]--;
             if (m_rem[k] == 0) m_st[k] = 2;
           end
        default: if (!pr) m_st[k] = 0;
      endcase
    end
  endtask

  task automatic cyc_pre();
    @(negedge clk);
    check_all();
  endtask
  task automatic cyc_post();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic cyc();
    cyc_pre();
    cyc_post();
  endtask

  typedef struct {
    bit rst, en, sm, rv; logic [3:0] s;
    bit e_rn, e_bc; logic [3:0] e_sy; logic [4:0] e_bk;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n, hi;
    bit ack_seen;
    tbl[0] = '{1, 1, 1, 0, 4'b0100, 1, 0, 4'b0000, 5'h1f};
    tbl[1] = '{1, 1, 0, 1, 4'b1000, 0, 1, 4'b1000, 5'h1f};
    tbl[2] = '{1, 1, 1, 1, 4'b0110, 1, 1, 4'b0010, 5'h1f};
    tbl[3] = '{1, 0, 1, 1, 4'b0001, 0, 0, 4'b0000, 5'h00};
    tbl[4] = '{1, 1, 1, 1, 4'b0000, 1, 1, 4'b0000, 5'h1f};
    tbl[5] = '{1, 1, 0, 1, 4'b1100, 0, 1, 4'b0100, 5'h1f};
    tbl[6] = '{0, 1, 1, 1, 4'b0001, 0, 0, 4'b0000, 5'h00};
    tbl[7] = '{1, 1, 1, 1, 4'b0001, 1, 1, 4'b0001, 5'h1f};

    rst_n = 0; ena = 0; smv = 0; rbv = 0; sel = 0; pr = 0; clr = 0;
    for (int k = 0; k < 3; k++) begin m_st[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_err[k] = 0; end
    cyc_post();
    cyc(); cyc();
    chk("rst_state", 0, ss[0], 0);
    chk("rst_ack", 0, pa[0], 0);
    chk("rst_stall", 0, sc0, 0);
    chk("rst_selerr", 0, se[0], 0);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst; ena = tbl[i].en; smv = tbl[i].sm; rbv = tbl[i].rv; sel = tbl[i].s;
      cyc_pre();
      chk("tbl_rn", i, rn[0], tbl[i].e_rn);
      chk("tbl_bc", i, bc[0], tbl[i].e_bc);
      chk("tbl_sy", i, sy[0], tbl[i].e_sy);
      chk("tbl_bk", i, bk[0], tbl[i].e_bk);
      cyc_post();
    end

    // Run gating with a starved buffer
    rst_n = 0; cyc(); rst_n = 1;
    ena = 1; smv = 1; rbv = 0; sel = 4'b0100;
    repeat (10) cyc();
    chk("stall10", 0, sc0, 10);
    chk("stall10", 2, sc2, 10);
    chk("gate_rn", 0, rn[0], 1);
    chk("gate_bk", 0, bk[0], 5'h1f);

    // Syntax select and sticky multi-hot flag
    rbv = 1; sel = 4'b1000; #1;
    chk("sel_1000", 0, sy[0], 4'b1000);
    cyc();
    sel = 4'b0110; #1;
    chk("sel_0110", 0, sy[0], 4'b0010);
    cyc();
    chk("selerr_set", 0, se[0], 1);
    sel = 4'b0001;
    repeat (3) cyc();
    chk("selerr_sticky", 0, se[0], 1);

    // Saturation and clear priority
    clr = 1; cyc(); clr = 0; rbv = 0;
    repeat (20) cyc();
    chk("stall_sat", 2, sc2, 15);
    chk("stall_20", 0, sc0, 20);
    clr = 1; cyc(); clr = 0;
    chk("stall_clr", 0, sc0, 0);
    chk("stall_clr", 2, sc2, 0);
    chk("selerr_clr", 0, se[0], 0);

    // Drain with ena toggling
    rbv = 1; ena = 1; pr = 1;
    cyc();
    chk("drain_enter", 0, ss[0], 1);
    chk("drain_front", 0, rn[0], 0);
    chk("zero_drain_state", 1, ss[1], 2);
    chk("zero_drain_ack", 1, pa[1], 1);
    n = 0; hi = 0;
    while (n < 100 && !pa[0]) begin
      ena = (n % 2) == 1;
      if (ss[0] == 2'd1 && ena) hi++;
      cyc();
      n++;
    end
    chk("drain_ack", 0, pa[0], 1);
    chk("drain_ena_cycles", 0, hi, 16);
    ena = 1; #1;
    chk("paused_rn", 0, rn[0], 0);
    chk("paused_bk", 0, bk[0], 0);
    cyc();
    pr = 0; cyc();
    chk("resume_state", 0, ss[0], 0);
    chk("resume_ack", 0, pa[0], 0);

    // Abort after five drain cycles
    pr = 1; cyc();
    ack_seen = 0;
    repeat (5) begin cyc(); ack_seen |= pa[0]; end
    pr = 0; cyc();
    chk("abort_state", 0, ss[0], 0);
    chk("abort_noack", 0, ack_seen | pa[0], 0);

    // Reset while draining
    pr = 1; cyc(); cyc();
    chk("pre_rst_drain", 0, ss[0], 1);
    rst_n = 0; #1;
    chk("rst_bk", 0, bk[0], 0);
    chk("rst_rn", 0, rn[0], 0);
    cyc();
    rst_n = 1; pr = 0; #1;
    chk("post_rst_state", 0, ss[0], 0);
    chk("post_rst_ack", 0, pa[0], 0);
    chk("post_rst_stall", 0, sc0, 0);
    chk("post_rst_rn", 0, rn[0], 1);
    cyc();

    // Randomized traffic against the model
    repeat (3000) begin
      rst_n = $urandom_range(0, 99) != 0;
      ena = ($urandom % 4) != 0;
      smv = $urandom % 2;
      rbv = $urandom % 2;
      sel = 4'($urandom);
      if ($urandom % 8 == 0) pr = ~pr;
      clr = ($urandom % 32) == 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
